// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding
// and the slice-counter width helper.
`ifndef SERIAL_ADD_SUB_PKG_SV
`define SERIAL_ADD_SUB_PKG_SV

package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Bits needed to count NUM_SIZE/SLICE_SIZE slices, never less than one
    function automatic int counterWidth(input int numSize, input int sliceSize);
        int width;
        width = $clog2(numSize / sliceSize);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

`endif

// File: rtl/serial_add_sub_slice_adder.sv
// One SLICE_SIZE-bit ripple slice: sum, carry out, and the carry that
// enters the slice MSB (needed for signed overflow on the top slice).
module slice_adder #(
    parameter int SLICE_SIZE = 8
) (
    input  logic [SLICE_SIZE-1:0] a,
    input  logic [SLICE_SIZE-1:0] b,
    input  logic                  cIn,
    output logic [SLICE_SIZE-1:0] sum,
    output logic                  cOut,
    output logic                  cMsbIn
);

    logic [SLICE_SIZE:0] fullSum;

    // Widened add; carry into the MSB is recovered from the MSB sum bit
    always_comb begin
        fullSum = {1'b0, a} + {1'b0, b} + {{SLICE_SIZE{1'b0}}, cIn};
        sum     = fullSum[SLICE_SIZE-1:0];
        cOut    = fullSum[SLICE_SIZE];
        cMsbIn  = fullSum[SLICE_SIZE-1] ^ a[SLICE_SIZE-1] ^ b[SLICE_SIZE-1];
    end

endmodule

// File: rtl/serial_add_sub.sv
// Slice-serial add/subtract with a valid/ready handshake on both sides.
// Subtraction is dIn0 + ~dIn1 + 1, with the +1 seeded into the carry.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int NUM_SIZE   = 32,
    parameter int SLICE_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inValid,
    output logic                inReady,
    input  logic                add,
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    output logic                outValid,
    input  logic                outReady,
    output logic [NUM_SIZE-1:0] dOut,
    output logic                carryOut,
    output logic                overflow,
    output logic                zero,
    output logic                negative
);

    localparam int NUM_SLICES = NUM_SIZE / SLICE_SIZE;
    localparam int CNT_W      = counterWidth(NUM_SIZE, SLICE_SIZE);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    stateT                 state;
    stateT                 nextState;
    logic [NUM_SIZE-1:0]   opA;
    logic [NUM_SIZE-1:0]   opB;
    logic                  addMode;
    logic                  carry;
    logic [CNT_W-1:0]      sliceCnt;
    logic [31:0]           bitBase;
    logic [SLICE_SIZE-1:0] sliceA;
    logic [SLICE_SIZE-1:0] sliceB;
    logic [SLICE_SIZE-1:0] sliceSum;
    logic                  sliceCOut;
    logic                  sliceCMsbIn;
    logic                  accept;
    logic                  lastSlice;

    // Select the current slice; the subtrahend is inverted here, ahead of the adder
    always_comb begin
        bitBase   = 32'(sliceCnt) * 32'(SLICE_SIZE);
        sliceA    = opA[bitBase +: SLICE_SIZE];
        sliceB    = addMode ? opB[bitBase +: SLICE_SIZE] : ~opB[bitBase +: SLICE_SIZE];
        lastSlice = (sliceCnt == LAST_SLICE);
        accept    = (state == IDLE) && inValid;
    end

    slice_adder #(.SLICE_SIZE(SLICE_SIZE)) uSliceAdder (
        .a      (sliceA),
        .b      (sliceB),
        .cIn    (carry),
        .sum    (sliceSum),
        .cOut   (sliceCOut),
        .cMsbIn (sliceCMsbIn)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        unique case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) nextState = RUN;
            end
            RUN: begin
                if (lastSlice) nextState = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Operand capture, one slice per RUN cycle, flags latched on the top slice
    always_ff @(posedge clk) begin
        if (rst) begin
            opA      <= '0;
            opB      <= '0;
            addMode  <= 1'b0;
            carry    <= 1'b0;
            sliceCnt <= '0;
            dOut     <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            opA      <= dIn0;
            opB      <= dIn1;
            addMode  <= add;
            carry    <= ~add;
            sliceCnt <= '0;
        end else if (state == RUN) begin
            dOut[bitBase +: SLICE_SIZE] <= sliceSum;
            carry    <= sliceCOut;
            sliceCnt <= sliceCnt + 1'b1;
            if (lastSlice) begin
                carryOut <= sliceCOut;
                overflow <= sliceCMsbIn ^ sliceCOut;
            end
        end
    end

    // Result-derived flags follow the held result directly
    always_comb begin
        zero     = (dOut == '0);
        negative = dOut[NUM_SIZE-1];
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter NUM_SIZE, default 32, shall set the operand and result width in bits.
REQ-002 Parameter SLICE_SIZE, default 8, shall set the bits processed per cycle; NUM_SIZE shall be an integer multiple of SLICE_SIZE.
REQ-003 Ports shall be:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  operands and mode are valid.
- inReady  output  1  block can accept an operation.
- add  input  1  high selects add, low selects sub.
- dIn0  input  NUM_SIZE  augend or minuend.
- dIn1  input  NUM_SIZE  addend or subtrahend.
- outValid  output  1  result and flags are valid.
- outReady  input  1  consumer accepts the result.
- dOut  output  NUM_SIZE  sum or difference, modulo 2^NUM_SIZE.
- carryOut  output  1  carry out of the MSB; on sub, 1 means no borrow (dIn0 >= dIn1 unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  dOut is all zeros.
- negative  output  1  dOut MSB.

Function
REQ-004 The FSM shall have three states: IDLE, RUN and DONE; inReady shall be high only in IDLE, and outValid shall be high only in DONE.
REQ-005 In IDLE, when inValid is high, the block shall capture dIn0, dIn1 and add, set the slice counter to 0, and go to RUN.
REQ-006 Sub shall compute dIn0 + ~dIn1 + 1; the carry register shall be initialised to ~add when the operands are captured.
REQ-007 Each RUN cycle shall process slice k (bits k*SLICE_SIZE upward), write that slice of dOut, update the carry register and increment k.
REQ-008 RUN shall last exactly NUM_SIZE/SLICE_SIZE cycles, then go to DONE; outValid shall rise NUM_SIZE/SLICE_SIZE+1 cycles after the accept edge (5 for the defaults).
REQ-009 When SLICE_SIZE equals NUM_SIZE, RUN shall last one cycle.
REQ-010 On the last slice, overflow shall equal the carry into the MSB XOR the carry out of the MSB, and carryOut shall equal the carry out of the MSB.
REQ-011 zero and negative shall be valid whenever outValid is high.
REQ-012 DONE shall hold dOut and all flags stable until outReady is high, then go to IDLE on that edge.
REQ-013 Because inReady is low in DONE, a new accept shall not occur in the same cycle as the result handshake.
REQ-014 inValid and any operand change during RUN or DONE shall be ignored and shall not disturb the result in progress.
REQ-015 outReady while not in DONE shall have no effect.

Reset
REQ-016 When rst is high at a clock edge, the state shall become IDLE in every state, including mid-RUN and in DONE.
REQ-017 On reset, inReady shall be 1; outValid, dOut, carryOut, overflow and negative shall be 0; zero shall be 1.
REQ-018 On reset, the operand, carry and counter registers shall be cleared, and any operation in progress shall be discarded with no outValid pulse.

Structure
REQ-019 The state encodings (IDLE, RUN, DONE) shall be defined in a shared include file behind an include guard, with the counter width derived as clog2(NUM_SIZE/SLICE_SIZE) (minimum 1).
REQ-020 One sub-module, slice_adder, shall be used: parameter SLICE_SIZE; inputs a, b and cIn; outputs sum, cOut and cMsbIn (the carry into its MSB).
REQ-021 The subtrahend inversion shall be done in serial_add_sub before slice_adder.
REQ-022 All registers in serial_add_sub shall be clocked only by clk.

Verification
REQ-023 The bench shall cover these directed scenarios with the default parameters:
- Add 0x000000FF + 0x00000001 -> dOut 0x00000100, carryOut 0, overflow 0, zero 0; outValid rises exactly 5 cycles after accept.
- Sub 5 - 7 -> dOut 0xFFFFFFFE, carryOut 0, negative 1, overflow 0.
- Add 0x7FFFFFFF + 1 -> dOut 0x80000000, overflow 1, negative 1.
- Sub 0x80000000 - 1 -> dOut 0x7FFFFFFF, overflow 1.
- Add 0xFFFFFFFF + 1 -> dOut 0, zero 1, carryOut 1.
- Hold outReady low for 3 cycles in DONE -> outputs stable throughout, inReady 0, and inValid with new operands ignored.
- Assert rst on the 2nd RUN cycle -> next cycle in IDLE, inReady 1, outValid 0, no result emitted; a following add 2 + 3 returns 5.
REQ-024 The bench shall repeat the add and sub scenarios with SLICE_SIZE=32 (1 RUN cycle) and SLICE_SIZE=1 (32 RUN cycles), checking both results and latency.
